// File: rtl/condition_code_unit_if.sv
// ALU output bus as seen by the Execute-stage consumers.
//   alu_result    : ALU result for the instruction in Execute
//   alu_overflow  : ALU signed overflow flag
//   alu_operation : operation select driven to the ALU (00 add, 01 sub, 10 and, 11 xor)
// master modport is the ALU side (drives), slave modport is the consumer side.
interface condition_code_unit_if #(
  parameter int BUS_WIDTH    = 64,
  parameter int SELECT_WIDTH = 2
);
  logic [BUS_WIDTH-1:0]    alu_result;
  logic                    alu_overflow;
  logic [SELECT_WIDTH-1:0] alu_operation;

  modport master (
    output alu_result,
    output alu_overflow,
    output alu_operation
  );

  modport slave (
    input alu_result,
    input alu_overflow,
    input alu_operation
  );
endinterface

// File: rtl/condition_code_unit.sv
// Y86 condition-code register and jXX/cmovXX condition evaluator.
// Captures ZF/SF/OF from the ALU output on OPq instructions and evaluates
// condition functions against the stored codes, returning a registered
// result one cycle after an accepted request.
//
// Ports:
//   clk        : clock, all state updates on rising edge
//   reset      : synchronous active-high reset
//   alu        : ALU output bus (slave modport)
//   set_cc     : load CC from the current ALU output
//   stall      : freeze all state this cycle
//   bubble     : squash current evaluation, clear output strobe
//   eval_valid : condition evaluation request
//   ifun       : condition function code (0..6 valid)
//   cc         : stored codes {ZF,SF,OF}
//   cnd        : registered condition result
//   cnd_valid  : strobe, one cycle after an accepted request
//   cnd_error  : accepted request had ifun > 6
module condition_code_unit #(
  parameter int BUS_WIDTH    = 64,
  parameter int SELECT_WIDTH = 2,
  parameter int IFUN_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  condition_code_unit_if.slave   alu,
  input  logic                   set_cc,
  input  logic                   stall,
  input  logic                   bubble,
  input  logic                   eval_valid,
  input  logic [IFUN_WIDTH-1:0]  ifun,
  output logic [2:0]             cc,
  output logic                   cnd,
  output logic                   cnd_valid,
  output logic                   cnd_error
);

  logic zf, sf, of_flag;
  logic zf_next, sf_next, of_next;
  logic cond_true;
  logic ifun_bad;

  assign zf      = cc[2];
  assign sf      = cc[1];
  assign of_flag = cc[0];

  // Flags derived from the ALU output; logical ops never overflow.
  assign zf_next = (alu.alu_result == '0);
  assign sf_next = alu.alu_result[BUS_WIDTH-1];
  assign of_next = alu.alu_operation[SELECT_WIDTH-1] ? 1'b0 : alu.alu_overflow;

  assign ifun_bad = (ifun > IFUN_WIDTH'(6));

  // Evaluated against the registered codes only: a same-cycle set_cc
  // is deliberately not forwarded.
  always_comb begin
    cond_true = 1'b0;
    case (ifun)
      IFUN_WIDTH'(0): cond_true = 1'b1;
      IFUN_WIDTH'(1): cond_true = (sf ^ of_flag) | zf;
      IFUN_WIDTH'(2): cond_true = sf ^ of_flag;
      IFUN_WIDTH'(3): cond_true = zf;
      IFUN_WIDTH'(4): cond_true = ~zf;
      IFUN_WIDTH'(5): cond_true = ~(sf ^ of_flag);
      IFUN_WIDTH'(6): cond_true = ~(sf ^ of_flag) & ~zf;
      default:        cond_true = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cc        <= 3'b100;
      cnd       <= 1'b0;
      cnd_valid <= 1'b0;
      cnd_error <= 1'b0;
    end else if (stall) begin
      cc        <= cc;
      cnd       <= cnd;
      cnd_valid <= cnd_valid;
      cnd_error <= cnd_error;
    end else if (bubble) begin
      cnd       <= 1'b0;
      cnd_valid <= 1'b0;
      cnd_error <= 1'b0;
    end else begin
      if (set_cc) begin
        cc <= {zf_next, sf_next, of_next};
      end
      if (eval_valid) begin
        cnd       <= cond_true & ~ifun_bad;
        cnd_valid <= 1'b1;
        cnd_error <= ifun_bad;
      end else begin
        cnd_valid <= 1'b0;
        cnd_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_condition_code_unit.sv
module tb_condition_code_unit;

  logic       clk;
  logic       reset;
  logic       set_cc;
  logic       stall;
  logic       bubble;
  logic       eval_valid;
  logic [3:0] ifun;
  logic [2:0] cc;
  logic       cnd;
  logic       cnd_valid;
  logic       cnd_error;

  int passed = 0;
  int total  = 0;

  condition_code_unit_if #(.BUS_WIDTH(64), .SELECT_WIDTH(2)) alu_bus ();

  condition_code_unit #(
    .BUS_WIDTH(64),
    .SELECT_WIDTH(2),
    .IFUN_WIDTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .alu(alu_bus.slave),
    .set_cc(set_cc),
    .stall(stall),
    .bubble(bubble),
    .eval_valid(eval_valid),
    .ifun(ifun),
    .cc(cc),
    .cnd(cnd),
    .cnd_valid(cnd_valid),
    .cnd_error(cnd_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input logic [2:0] e_cc, input logic e_cnd,
                           input logic e_valid, input logic e_err);
    check({tag, ".cc"},        {5'd0, cc},        {5'd0, e_cc});
    check({tag, ".cnd"},       {7'd0, cnd},       {7'd0, e_cnd});
    check({tag, ".cnd_valid"}, {7'd0, cnd_valid}, {7'd0, e_valid});
    check({tag, ".cnd_error"}, {7'd0, cnd_error}, {7'd0, e_err});
  endtask

  task automatic drive(input logic sc, input logic [63:0] res, input logic ov,
                       input logic [1:0] op, input logic ev, input logic [3:0] fn);
    set_cc                = sc;
    alu_bus.alu_result    = res;
    alu_bus.alu_overflow  = ov;
    alu_bus.alu_operation = op;
    eval_valid            = ev;
    ifun                  = fn;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    bubble = 1'b0;
    drive(1'b0, 64'd0, 1'b0, 2'b00, 1'b0, 4'd0);
    tick();
    tick();
    check_out("reset", 3'b100, 1'b0, 1'b0, 1'b0);

    reset = 1'b0;
    drive(1'b0, 64'd0, 1'b0, 2'b00, 1'b1, 4'd3);
    tick();
    check_out("default_e", 3'b100, 1'b1, 1'b1, 1'b0);

    // move CC away from default so the no-forward case is observable
    drive(1'b1, 64'd5, 1'b0, 2'b00, 1'b0, 4'd0);
    tick();
    check_out("add_pos", 3'b000, 1'b1, 1'b0, 1'b0);

    // subtract to zero with same-cycle le request: old flags 000 -> 0
    drive(1'b1, 64'd0, 1'b0, 2'b01, 1'b1, 4'd1);
    tick();
    check_out("sub_zero_noforward", 3'b100, 1'b0, 1'b1, 1'b0);

    drive(1'b0, 64'd0, 1'b0, 2'b00, 1'b1, 4'd4);
    tick();
    check_out("ne_after_zero", 3'b100, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 64'd0, 1'b0, 2'b00, 1'b1, 4'd3);
    tick();
    check_out("e_after_zero", 3'b100, 1'b1, 1'b1, 1'b0);

    // signed overflow
    drive(1'b1, 64'h8000_0000_0000_0000, 1'b1, 2'b00, 1'b0, 4'd0);
    tick();
    check_out("ovf_set", 3'b011, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 64'd0, 1'b0, 2'b00, 1'b1, 4'd2);
    tick();
    check_out("ovf_l", 3'b011, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 64'd0, 1'b0, 2'b00, 1'b1, 4'd5);
    tick();
    check_out("ovf_ge", 3'b011, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 64'd0, 1'b0, 2'b00, 1'b1, 4'd6);
    tick();
    check_out("ovf_g", 3'b011, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 64'd0, 1'b0, 2'b00, 1'b1, 4'd1);
    tick();
    check_out("ovf_le", 3'b011, 1'b0, 1'b1, 1'b0);

    // xor clears OF despite alu_overflow=1
    drive(1'b1, 64'h5, 1'b1, 2'b11, 1'b0, 4'd0);
    tick();
    check_out("xor_clear_of", 3'b000, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 64'd0, 1'b0, 2'b00, 1'b1, 4'd6);
    tick();
    check_out("xor_g", 3'b000, 1'b1, 1'b1, 1'b0);

    // and with negative result: SF=1, OF forced 0
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2'b10, 1'b0, 4'd0);
    tick();
    check_out("and_neg", 3'b010, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 64'd0, 1'b0, 2'b00, 1'b1, 4'd2);
    tick();
    check_out("and_l", 3'b010, 1'b1, 1'b1, 1'b0);

    // zero test must cover upper bits below the MSB
    drive(1'b1, 64'h0100_0000_0000_0000, 1'b0, 2'b00, 1'b0, 4'd0);
    tick();
    check_out("upper_nonzero", 3'b000, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 64'd0, 1'b0, 2'b00, 1'b1, 4'd3);
    tick();
    check_out("upper_e", 3'b000, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 64'd0, 1'b0, 2'b00, 1'b1, 4'd4);
    tick();
    check_out("upper_ne", 3'b000, 1'b1, 1'b1, 1'b0);

    // stall with set_cc and eval for 3 cycles: everything holds
    stall = 1'b1;
    drive(1'b1, 64'd0, 1'b0, 2'b00, 1'b1, 4'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("stall%0d", i), 3'b000, 1'b1, 1'b1, 1'b0);
    end
    stall = 1'b0;

    // bubble: CC held, outputs cleared
    bubble = 1'b1;
    drive(1'b1, 64'd0, 1'b0, 2'b00, 1'b1, 4'd0);
    tick();
    check_out("bubble", 3'b000, 1'b0, 1'b0, 1'b0);
    bubble = 1'b0;

    drive(1'b0, 64'd0, 1'b0, 2'b00, 1'b1, 4'd0);
    tick();
    check_out("always", 3'b000, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 64'd0, 1'b0, 2'b00, 1'b0, 4'd0);
    tick();
    check_out("idle_hold", 3'b000, 1'b1, 1'b0, 1'b0);

    // invalid ifun
    drive(1'b0, 64'd0, 1'b0, 2'b00, 1'b1, 4'd9);
    tick();
    check_out("bad_ifun", 3'b000, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 64'd0, 1'b0, 2'b00, 1'b0, 4'd0);
    tick();
    check_out("bad_idle", 3'b000, 1'b0, 1'b0, 1'b0);

    drive(1'b0, 64'd0, 1'b0, 2'b00, 1'b1, 4'd15);
    tick();
    check_out("bad_ifun15", 3'b000, 1'b0, 1'b1, 1'b1);

    // reset mid-sequence wins over set_cc and eval
    reset = 1'b1;
    drive(1'b1, 64'h8000_0000_0000_0000, 1'b1, 2'b00, 1'b1, 4'd0);
    tick();
    check_out("mid_reset", 3'b100, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    drive(1'b0, 64'd0, 1'b0, 2'b00, 1'b0, 4'd0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/condition_code_unit.md
Name: condition_code_unit

Overview:
- Consumer end of the ALU output interface (result, overflow_flag, operation select) in the Y86 datapath.
- Derives ZF/SF/OF from each ALU result and holds them in the condition-code register.
- Evaluates Y86 jXX/cmovXX conditions against the stored codes and returns a registered cnd with a valid strobe.
- Sits beside the ALU in the Execute stage and supports stall and bubble control from pipeline control logic.

Parameters:
BUS_WIDTH, 64, width of ALU result bus
SELECT_WIDTH, 2, width of ALU operation select (00 add, 01 sub, 10 and, 11 xor)
IFUN_WIDTH, 4, width of condition function code

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
alu_result  input  BUS_WIDTH  ALU result for the instruction in Execute
alu_overflow  input  1  ALU overflow_flag
alu_operation  input  SELECT_WIDTH  operation select driven to the ALU this cycle
set_cc  input  1  instruction in Execute is OPq; load CC from current ALU output
stall  input  1  freeze all state (CC and output registers) this cycle
bubble  input  1  squash current evaluation; output strobe cleared
eval_valid  input  1  condition evaluation request this cycle
ifun  input  IFUN_WIDTH  condition code: 0 always, 1 le, 2 l, 3 e, 4 ne, 5 ge, 6 g
cc  output  3  stored codes {ZF,SF,OF}
cnd  output  1  registered condition result
cnd_valid  output  1  cnd valid strobe, one cycle after accepted eval_valid
cnd_error  output  1  registered; accepted request had ifun > 6

Behaviour:
- Reset, synchronous, has priority over all other inputs: ZF=1, SF=0, OF=0 (cc=3'b100); cnd=0, cnd_valid=0, cnd_error=0.
- Priority order each edge: reset > stall > bubble > normal.
- CC update: on an edge with set_cc=1, stall=0, bubble=0:
  - ZF <= (alu_result == 0) across all BUS_WIDTH bits.
  - SF <= alu_result[BUS_WIDTH-1].
  - OF <= alu_overflow when alu_operation[1]=0 (add/sub); OF <= 0 for and/xor, regardless of alu_overflow.
- CC is unchanged when set_cc=0, stall=1, or bubble=1.
- Evaluation:
  - An accepted request (eval_valid=1, stall=0, bubble=0) uses the CC value held before this edge.
  - A simultaneous set_cc does not forward: the new flags are visible to requests one cycle later.
  - Latency is 1 cycle: cnd and cnd_valid are registered.
- Condition functions, using the current ZF/SF/OF:
  - 0: 1
  - 1: (SF^OF)|ZF
  - 2: SF^OF
  - 3: ZF
  - 4: ~ZF
  - 5: ~(SF^OF)
  - 6: ~(SF^OF)&~ZF
- ifun 7..15: cnd=0, cnd_error=1, cnd_valid=1.
- No accepted request (eval_valid=0, stall=0): next cnd_valid=0, cnd_error=0; cnd holds its last value.
- stall=1: cc, cnd, cnd_valid, cnd_error all hold; eval_valid and set_cc are ignored, with no queuing.
- bubble=1 (stall=0): cnd_valid <= 0, cnd_error <= 0, cnd <= 0; CC held even if set_cc=1.
- Reset asserted mid-sequence: the next edge yields reset values; any in-flight evaluation is lost.
- cc output is always the register value, never a combinational bypass.
- Width rules: the zero test covers the full bus. SF is always the MSB for any BUS_WIDTH >= 2.

Test Plan:
- Reset and default codes: hold reset 2 cycles, then eval ifun=3 -> cc=100; next cycle cnd=1, cnd_valid=1.
- Subtract to zero: alu_result=0, alu_overflow=0, op=01, set_cc -> cc=100. Same-cycle eval ifun=1 uses old flags. Eval ifun=4 next cycle -> cnd=0.
- Signed overflow: result=64'h8000_0000_0000_0000, overflow=1, op=00, set_cc -> cc=011.
  - ifun=2 -> cnd=0
  - ifun=5 -> cnd=1
  - ifun=6 -> cnd=1
- Logical op clears OF: prior cc=011; op=11, result=64'h5, alu_overflow forced 1, set_cc -> cc=000. Then ifun=6 -> cnd=1.
- Stall/bubble:
  - stall=1 with set_cc and eval_valid for 3 cycles -> cc, cnd, cnd_valid unchanged.
  - bubble=1 with set_cc=1 -> cc unchanged, cnd_valid=0.
- Invalid ifun: eval ifun=9 -> next cycle cnd=0, cnd_valid=1, cnd_error=1. Following idle cycle -> cnd_valid=0, cnd_error=0.
